mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_req_fsm.sv | 37 +++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the memory stage
package mem_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_IDX_W  = 5;
    localparam int WAIT_CNT_W = 8;

    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_req_fsm.sv
// rtl/mem_req_fsm.sv - request/wait handshake FSM producing mem_req and stall
module mem_req_fsm
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic access,
    input  logic mem_ack,
    output logic mem_req,
    output logic stall
);

    mem_state_e state;

    // Enter WAIT when an access is not acknowledged in its first cycle; leave on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (access && !mem_ack) state <= WAIT;
                WAIT:    if (mem_ack)            state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request is combinational so a zero-wait ack completes in the issuing cycle
    always_comb begin
        mem_req = 1'b0;
        if (!rst) begin
            mem_req = (state == WAIT) ? 1'b1 : access;
        end
        stall = mem_req & ~mem_ack;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage (optional alignment check: MEM_STAGE_ALIGN_CHECK_EN)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ALU_output,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_IDX_W-1:0]  rt_or_rd,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  write_reg,
    input  logic                  write_back,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_W-1:0]     o_ALU_output,
    output logic [DATA_W-1:0]     o_readDataFromMemory,
    output logic [REG_IDX_W-1:0]  o_rt_or_rd,
    output logic                  o_write_reg,
    output logic                  o_write_back,
    output logic                  stall,
    output logic [WAIT_CNT_W-1:0] o_wait_cycles
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic                  o_misaligned
`endif
);

    logic              access_raw;
    logic              misaligned;
    logic              access;
    logic              read_done;
    logic [DATA_W-1:0] rdata_q;

    // A misaligned access is suppressed entirely and squashes the writeback
    always_comb begin
        access_raw = mem_read | mem_write;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        misaligned = access_raw & (ALU_output[1:0] != 2'b00) & ~rst;
`else
        misaligned = 1'b0;
`endif
        access = access_raw & ~misaligned;
    end

    mem_req_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .access  (access),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .stall   (stall)
    );

    // Datapath muxing; a read+write request behaves as a pure write
    always_comb begin
        read_done            = mem_ack & mem_req & mem_read & ~mem_write;
        mem_we               = mem_write & mem_req;
        mem_addr             = ALU_output;
        mem_wdata            = write_data;
        o_ALU_output         = ALU_output;
        o_rt_or_rd           = rt_or_rd;
        o_readDataFromMemory = read_done ? mem_rdata : rdata_q;
        o_write_reg          = write_reg  & ~stall & ~misaligned & ~rst;
        o_write_back         = write_back & ~stall & ~misaligned & ~rst;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        o_misaligned         = misaligned;
`endif
    end

    // Hold the last completed load's data for the cycles after its ack
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (read_done) begin
            rdata_q <= mem_rdata;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wait_cycles <= '0;
        end else if (stall && (o_wait_cycles != WAIT_CNT_MAX)) begin
            o_wait_cycles <= o_wait_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_output, write_data, mem_rdata;
    logic [4:0]  rt_or_rd;
    logic        mem_read, mem_write, write_reg, write_back, mem_ack;
    logic        mem_req, mem_we, stall, o_write_reg, o_write_back;
    logic [31:0] mem_addr, mem_wdata, o_ALU_output, o_readDataFromMemory;
    logic [4:0]  o_rt_or_rd;
    logic [7:0]  o_wait_cycles;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic        o_misaligned;
`endif

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_rdata;
    int          m_wait;

    mem_stage dut (
        .clk(clk), .rst(rst), .ALU_output(ALU_output), .write_data(write_data),
        .rt_or_rd(rt_or_rd), .mem_read(mem_read), .mem_write(mem_write),
        .write_reg(write_reg), .write_back(write_back), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .o_ALU_output(o_ALU_output),
        .o_readDataFromMemory(o_readDataFromMemory), .o_rt_or_rd(o_rt_or_rd),
        .o_write_reg(o_write_reg), .o_write_back(o_write_back), .stall(stall),
        .o_wait_cycles(o_wait_cycles)
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        , .o_misaligned(o_misaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic wreg, input logic wb);
        mem_read = rd; mem_write = wr; ALU_output = addr; write_data = wd;
        write_reg = wreg; write_back = wb; rt_or_rd = 5'($urandom);
    endtask

    // inputs change just after a falling edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ack = 1'b0;
        tick();
        rst = 1'b0;
        m_wait = 0; m_rdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_in(1'b1, 1'b1, 32'h100, 32'h55, 1'b1, 1'b1);
        mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
        total++; if (o_write_reg !== 1'b0 || o_write_back !== 1'b0) begin bad++; $display("FAIL rst_wb got=%b%b exp=00", o_write_reg, o_write_back); end
        tick();
        rst = 1'b0; set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        m_wait = 0; m_rdata = 32'h0;
        #1;
        total++; if (o_wait_cycles !== 8'd0) begin bad++; $display("FAIL rst_wait got=%0d exp=0", o_wait_cycles); end
        total++; if (o_readDataFromMemory !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", o_readDataFromMemory); end
        tick();
    endtask

    task automatic test_load_zero_wait();
        set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL zw_stall got=%b exp=0", stall); end
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL zw_req got=%b/%h exp=1/10", mem_req, mem_addr); end
        total++; if (o_readDataFromMemory !== 32'hDEAD_BEEF) begin bad++; $display("FAIL zw_rdata got=%h exp=deadbeef", o_readDataFromMemory); end
        total++; if (o_write_reg !== 1'b1) begin bad++; $display("FAIL zw_wreg got=%b exp=1", o_write_reg); end
        tick();
        m_rdata = 32'hDEAD_BEEF;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL zw_idle got=%b exp=0", mem_req); end
        total++; if (o_readDataFromMemory !== m_rdata) begin bad++; $display("FAIL zw_hold got=%h exp=%h", o_readDataFromMemory, m_rdata); end
        tick();
    endtask

    task automatic test_load_wait();
        do_reset();
        set_in(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1);
        for (int k = 0; k <= 3; k++) begin
            mem_ack = (k == 3); mem_rdata = (k == 3) ? 32'h1234_5678 : $urandom;
            #1;
            total++; if (stall !== (k < 3)) begin bad++; $display("FAIL lw_stall k=%0d got=%b exp=%b", k, stall, k < 3); end
            total++; if (o_write_reg !== (k == 3)) begin bad++; $display("FAIL lw_wreg k=%0d got=%b exp=%b", k, o_write_reg, k == 3); end
            if (k == 3) begin
                total++; if (o_readDataFromMemory !== 32'h1234_5678) begin bad++; $display("FAIL lw_rdata got=%h exp=12345678", o_readDataFromMemory); end
            end
            tick();
            if (k < 3) m_wait++;
        end
        m_rdata = 32'h1234_5678;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); mem_ack = 1'b0;
        #1;
        total++; if (o_wait_cycles !== 8'd3) begin bad++; $display("FAIL lw_wait got=%0d exp=3", o_wait_cycles); end
        total++; if (o_readDataFromMemory !== 32'h1234_5678) begin bad++; $display("FAIL lw_hold got=%h exp=12345678", o_readDataFromMemory); end
        tick();
    endtask

    task automatic test_store();
        set_in(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001;
        #1;
        total++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL st_we got=%b/%h exp=1/cafef00d", mem_we, mem_wdata); end
        total++; if (o_readDataFromMemory !== m_rdata) begin bad++; $display("FAIL st_rdata got=%h exp=%h", o_readDataFromMemory, m_rdata); end
        tick();
        set_in(1'b1, 1'b1, 32'h24, 32'h0BAD_CAFE, 1'b1, 1'b0);
        for (int k = 0; k <= 1; k++) begin
            mem_ack = (k == 1); mem_rdata = 32'hBAD0_0002;
            #1;
            total++; if (mem_we !== 1'b1 || stall !== (k == 0)) begin bad++; $display("FAIL rw_we k=%0d got=%b/%b exp=1/%b", k, mem_we, stall, k == 0); end
            total++; if (o_readDataFromMemory !== m_rdata) begin bad++; $display("FAIL rw_rdata k=%0d got=%h exp=%h", k, o_readDataFromMemory, m_rdata); end
            tick();
            if (k == 0) m_wait++;
        end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); mem_ack = 1'b0;
        #1;
        total++; if (o_readDataFromMemory !== m_rdata) begin bad++; $display("FAIL rw_hold got=%h exp=%h", o_readDataFromMemory, m_rdata); end
        tick();
    endtask

    task automatic test_nop_stray_ack();
        set_in(1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL nop_req got=%b/%b exp=0/0", mem_req, stall); end
        total++; if (o_write_reg !== 1'b1) begin bad++; $display("FAIL nop_wreg got=%b exp=1", o_write_reg); end
        total++; if (o_readDataFromMemory !== m_rdata) begin bad++; $display("FAIL nop_rdata got=%h exp=%h", o_readDataFromMemory, m_rdata); end
        tick();
        mem_ack = 1'b0;
        #1;
        total++; if (o_readDataFromMemory !== m_rdata || o_wait_cycles !== 8'(m_wait)) begin bad++; $display("FAIL nop_after got=%h/%0d exp=%h/%0d", o_readDataFromMemory, o_wait_cycles, m_rdata, m_wait); end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1); mem_ack = 1'b0;
        for (int k = 0; k < 300; k++) tick();
        #1;
        total++; if (o_wait_cycles !== 8'd255) begin bad++; $display("FAIL sat_wait got=%0d exp=255", o_wait_cycles); end
        total++; if (stall !== 1'b1 || mem_req !== 1'b1) begin bad++; $display("FAIL sat_stall got=%b/%b exp=1/1", stall, mem_req); end
        rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b/%b exp=0/0", mem_req, stall); end
        tick();
        rst = 1'b0; m_wait = 0; m_rdata = 32'h0;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        total++; if (o_wait_cycles !== 8'd0) begin bad++; $display("FAIL midrst_wait got=%0d exp=0", o_wait_cycles); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b exp=0", mem_req); end
        tick();
    endtask

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    task automatic test_misaligned();
        set_in(1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 1'b1); mem_ack = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_req got=%b/%b exp=0/0", mem_req, stall); end
        total++; if (o_misaligned !== 1'b1 || o_write_reg !== 1'b0) begin bad++; $display("FAIL mis_flag got=%b/%b exp=1/0", o_misaligned, o_write_reg); end
        tick();
        set_in(1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b1); mem_ack = 1'b1; mem_rdata = 32'h0000_0014;
        #1;
        total++; if (mem_req !== 1'b1 || o_misaligned !== 1'b0 || o_write_reg !== 1'b1) begin bad++; $display("FAIL al_req got=%b/%b/%b exp=1/0/1", mem_req, o_misaligned, o_write_reg); end
        tick();
        m_rdata = 32'h0000_0014;
        mem_ack = 1'b0;
    endtask
`endif

    task automatic test_random();
        int          op, dly;
        logic [31:0] addr;
        logic        rd, wr, wreg, wb, acc, mis, ack, exp_stall, exp_req;
        logic [31:0] rdat, exp_rdata;
        for (int t = 0; t < 60; t++) begin
            op = $urandom_range(0, 3);
            rd = (op == 1) || (op == 3);
            wr = (op == 2) || (op == 3);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            wreg = 1'($urandom); wb = 1'($urandom);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            mis = (rd || wr) && (addr[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            acc = (rd || wr) && !mis;
            dly = acc ? $urandom_range(0, 3) : 0;
            set_in(rd, wr, addr, $urandom, wreg, wb);
            for (int k = 0; k <= dly; k++) begin
                ack = acc ? (k == dly) : 1'($urandom);
                rdat = $urandom;
                mem_ack = ack; mem_rdata = rdat;
                exp_req = acc;
                exp_stall = acc && !ack;
                exp_rdata = (acc && ack && rd && !wr) ? rdat : m_rdata;
                #1;
                total++; if (mem_req !== exp_req || stall !== exp_stall) begin bad++; $display("FAIL rnd_req t=%0d k=%0d got=%b/%b exp=%b/%b", t, k, mem_req, stall, exp_req, exp_stall); end
                total++; if (mem_we !== (acc && wr) || mem_addr !== addr || o_rt_or_rd !== rt_or_rd) begin bad++; $display("FAIL rnd_we t=%0d got=%b/%h exp=%b/%h", t, mem_we, mem_addr, acc && wr, addr); end
                total++; if (o_write_reg !== (wreg && !exp_stall && !mis) || o_write_back !== (wb && !exp_stall && !mis)) begin bad++; $display("FAIL rnd_wb t=%0d k=%0d got=%b%b exp=%b%b", t, k, o_write_reg, o_write_back, wreg && !exp_stall && !mis, wb && !exp_stall && !mis); end
                total++; if (o_readDataFromMemory !== exp_rdata) begin bad++; $display("FAIL rnd_rdata t=%0d k=%0d got=%h exp=%h", t, k, o_readDataFromMemory, exp_rdata); end
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                total++; if (o_misaligned !== mis) begin bad++; $display("FAIL rnd_mis t=%0d got=%b exp=%b", t, o_misaligned, mis); end
`endif
                tick();
                m_rdata = exp_rdata;
                if (exp_stall && m_wait < 255) m_wait++;
                total++; if (o_wait_cycles !== 8'(m_wait)) begin bad++; $display("FAIL rnd_wait t=%0d got=%0d exp=%0d", t, o_wait_cycles, m_wait); end
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        m_wait = 0; m_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_load_zero_wait();
        test_load_wait();
        test_store();
        test_nop_stray_ack();
        test_saturation();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        test_misaligned();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
